// File: rtl/rv32_hazard_ctrl_if.sv
// Hazard-control bundle between the RV32 pipeline datapath and rv32_hazard_ctrl.
// master: the pipeline (drives stage register indices/flags, consumes controls).
// slave:  the hazard controller.
interface rv32_hazard_ctrl_if;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_reg_write, ex_mem_read;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        ex_redirect, mem_busy;
  logic        tick_tock, pc_en, if_id_en, if_id_flush, id_ex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write,
           ex_redirect, mem_busy,
    input  tick_tock, pc_en, if_id_en, if_id_flush, id_ex_bubble,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write,
           ex_redirect, mem_busy,
    output tick_tock, pc_en, if_id_en, if_id_flush, id_ex_bubble,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/rv32_hazard_ctrl.sv
// RV32 hazard controller: stall/flush/bubble decode, EX operand forwarding
// select and saturating stall/flush counters. The pipeline advances only on
// cycles where tick_tock=1; all enables are forced low on the other phase.
// Optional feature macro: RV32_HAZARD_FORWARDING_EN
//   defined   -> MEM/WB forwarding, only load-use stalls
//   undefined -> no forwarding, stall on any EX/MEM producer of a used source

// Per-source hazard/forward slice; one instance per register source.
module rv32_hazard_src_lane (
  input  logic [4:0] id_rs,
  input  logic       id_use,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic       hazard,
  output logic [1:0] fwd
);
  logic ex_match;
  logic unused_lane;

  // x0 never produces a dependency
  assign ex_match = id_use && (ex_rd != 5'd0) && (id_rs == ex_rd);

`ifdef RV32_HAZARD_FORWARDING_EN
  logic mem_fwd, wb_fwd;
  assign mem_fwd = mem_reg_write && (mem_rd != 5'd0) && (ex_rs == mem_rd);
  assign wb_fwd  = wb_reg_write  && (wb_rd  != 5'd0) && (ex_rs == wb_rd);
  // only a load in EX cannot be bypassed in time
  assign hazard  = ex_match && ex_mem_read;
  // youngest producer (MEM) wins over WB
  assign fwd     = mem_fwd ? 2'b10 : (wb_fwd ? 2'b01 : 2'b00);
  // load detection keys off ex_mem_read alone
  assign unused_lane = ex_reg_write;
`else
  logic mem_match;
  assign mem_match = id_use && mem_reg_write && (mem_rd != 5'd0) && (id_rs == mem_rd);
  assign hazard    = (ex_match && ex_reg_write) || mem_match;
  assign fwd       = 2'b00;
  // forwarding-only inputs are ignored in this build
  assign unused_lane = ^{ex_mem_read, ex_rs, wb_rd, wb_reg_write};
`endif
endmodule

module rv32_hazard_ctrl (
  input  logic                 clk,
  input  logic                 rst_n,
  rv32_hazard_ctrl_if.slave    hz
);
  localparam int NUM_SRC = 2;

  typedef enum logic [1:0] {RUN, STALL, FLUSH, WAIT_MEM} state_t;

  state_t                    state_q, state_d;
  logic                      tick_tock_q;
  logic                      adv;
  logic                      data_hazard;
  logic [15:0]               stall_cnt_q, flush_cnt_q;

  logic [NUM_SRC-1:0][4:0]   id_rs, ex_rs;
  logic [NUM_SRC-1:0]        id_use, src_hazard;
  logic [NUM_SRC-1:0][1:0]   src_fwd;

  assign id_rs  = {hz.id_rs2, hz.id_rs1};
  assign id_use = {hz.id_use_rs2, hz.id_use_rs1};
  assign ex_rs  = {hz.ex_rs2, hz.ex_rs1};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    rv32_hazard_src_lane u_lane (
      .id_rs        (id_rs[g]),
      .id_use       (id_use[g]),
      .ex_rs        (ex_rs[g]),
      .ex_rd        (hz.ex_rd),
      .ex_reg_write (hz.ex_reg_write),
      .ex_mem_read  (hz.ex_mem_read),
      .mem_rd       (hz.mem_rd),
      .mem_reg_write(hz.mem_reg_write),
      .wb_rd        (hz.wb_rd),
      .wb_reg_write (hz.wb_reg_write),
      .hazard       (src_hazard[g]),
      .fwd          (src_fwd[g])
    );
  end

  assign data_hazard = |src_hazard;
  assign hz.fwd_a    = src_fwd[0];
  assign hz.fwd_b    = src_fwd[1];

  // rst_n gating keeps every enable low for the whole reset window
  assign adv = tick_tock_q && rst_n;

  // phase toggle and FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_tock_q <= 1'b0;
      state_q     <= RUN;
    end else begin
      tick_tock_q <= ~tick_tock_q;
      state_q     <= state_d;
    end
  end

  // next state: decided only in advance cycles, held otherwise
  always_comb begin
    state_d = state_q;
    if (adv) begin
      if (hz.mem_busy)         state_d = WAIT_MEM;
      else if (hz.ex_redirect) state_d = FLUSH;
      else if (data_hazard)    state_d = STALL;
      else                     state_d = RUN;
    end
  end

  // output decode of the decision taken this advance cycle
  always_comb begin
    hz.pc_en        = 1'b0;
    hz.if_id_en     = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_bubble = 1'b0;
    if (adv) begin
      unique case (state_d)
        RUN: begin
          hz.pc_en    = 1'b1;
          hz.if_id_en = 1'b1;
        end
        FLUSH: begin
          hz.pc_en        = 1'b1;
          hz.if_id_en     = 1'b1;
          hz.if_id_flush  = 1'b1;
          hz.id_ex_bubble = 1'b1;
        end
        STALL:    hz.id_ex_bubble = 1'b1;
        WAIT_MEM: ;
        default:  ;
      endcase
    end
  end

  // saturating performance counters, bumped once per stall/flush decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (adv && (state_d == STALL) && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (adv && (state_d == FLUSH) && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign hz.tick_tock = tick_tock_q;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
endmodule
